// File: rtl/lcd_pwr_seq_pkg.sv
// Shared types and constants for the LCD power/reset sequencer.
// Holds the sequencer state enum, default cycle counts, the relock counter
// width and the registered output bundle with its per-state decode.
package lcd_pwr_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    LCD_LOW   = 3'd3,
    LCD_WAIT  = 3'd4,
    RUN       = 3'd5
  } state_e;

  localparam int unsigned DEF_PLL_RST_CYC      = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 1_000_000;
  localparam int unsigned DEF_LOCK_STABLE_CYC  = 4096;
  localparam int unsigned DEF_LCD_RST_LOW_CYC  = 700_000;
  localparam int unsigned DEF_LCD_RST_WAIT_CYC = 8_400_000;
  localparam int unsigned DEF_CNT_W            = 24;
  localparam int unsigned RELOCK_CNT_W         = 4;

  // Outputs that are a pure function of the sequencer state.
  typedef struct packed {
    logic pll_reset;
    logic lcd_rst_n;
    logic sys_rst_n;
    logic bl_en;
    logic ready;
  } seq_out_t;

  localparam seq_out_t OUT_RST = '{pll_reset: 1'b1, lcd_rst_n: 1'b0,
                                   sys_rst_n: 1'b0, bl_en: 1'b0, ready: 1'b0};

  function automatic seq_out_t decode_outs(state_e s);
    seq_out_t o;
    o.pll_reset = (s == PLL_RST);
    o.lcd_rst_n = (s == LCD_WAIT) || (s == RUN);
    o.sys_rst_n = (s == RUN);
    o.bl_en     = (s == RUN);
    o.ready     = (s == RUN);
    return o;
  endfunction

endpackage

// File: rtl/lcd_pwr_seq_if.sv
// Signal bundle between the power sequencer and the PLL / panel / LCD logic.
//   pll_lock   : PLL lock, asynchronous to clk (driven by slave side)
//   pll_reset  : active-high PLL reset
//   lcd_rst_n  : panel hardware reset, active low
//   sys_rst_n  : active-low reset to downstream LCD logic
//   bl_en      : backlight enable
//   ready      : sequence complete (RUN)
//   lock_lost  : sticky, lock dropped while in RUN
//   relock_cnt : saturating count of PLL re-reset events
// master = sequencer, slave = PLL / panel / downstream consumer.
interface lcd_pwr_seq_if;
  import lcd_pwr_seq_pkg::*;

  logic                    pll_lock;
  logic                    pll_reset;
  logic                    lcd_rst_n;
  logic                    sys_rst_n;
  logic                    bl_en;
  logic                    ready;
  logic                    lock_lost;
  logic [RELOCK_CNT_W-1:0] relock_cnt;

  modport master (
    input  pll_lock,
    output pll_reset, lcd_rst_n, sys_rst_n, bl_en, ready, lock_lost, relock_cnt
  );

  modport slave (
    output pll_lock,
    input  pll_reset, lcd_rst_n, sys_rst_n, bl_en, ready, lock_lost, relock_cnt
  );
endinterface

// File: rtl/lcd_pwr_seq_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
//   clk, rst_n : clock and async active-low reset
//   d          : asynchronous input
//   q          : synchronized output, two edges behind d
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb sync_d = {sync_q[0], d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[1];

endmodule

// File: rtl/lcd_pwr_seq.sv
// LCD power-up / reset sequencer downstream of the LCD PLL.
// Resets the PLL, waits for a stable synchronized lock, pulses the panel
// reset, waits out the panel recovery time, then releases sys_rst_n, bl_en
// and ready. Runs on the free-running oscillator that also feeds the PLL.
// Ports:
//   clk, rst_n : oscillator clock, async active-low reset
//   bus        : lcd_pwr_seq_if.master (pll_lock in; resets, enables, status out)
// Build option: define LCD_PWR_SEQ_RELOCK_EN to make a lock loss in RUN restart
// the sequence from PLL_RST; otherwise RUN holds until rst_n and a lock loss
// only sets lock_lost.
module lcd_pwr_seq
  import lcd_pwr_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYC      = DEF_PLL_RST_CYC,
  parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int unsigned LCD_RST_LOW_CYC  = DEF_LCD_RST_LOW_CYC,
  parameter int unsigned LCD_RST_WAIT_CYC = DEF_LCD_RST_WAIT_CYC,
  parameter int unsigned CNT_W            = DEF_CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  lcd_pwr_seq_if.master bus
);

  logic                    lock_s;
  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        tmr_q, tmr_d;
  logic                    tmr_exp;
  logic                    relock_evt;
  seq_out_t                out_q, out_d;
  logic                    lock_lost_q, lock_lost_d;
  logic [RELOCK_CNT_W-1:0] relock_cnt_q, relock_cnt_d;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.pll_lock),
    .q     (lock_s)
  );

  // Timer value loaded on entry to each state; a count of 2^CNT_W loads as 0
  // and wraps through the full range, so it still lasts exactly that long.
  function automatic logic [CNT_W-1:0] tmr_load(state_e s);
    logic [CNT_W-1:0] ld;
    unique case (s)
      PLL_RST:   ld = CNT_W'(PLL_RST_CYC);
      WAIT_LOCK: ld = CNT_W'(LOCK_TIMEOUT_CYC);
      STABLE:    ld = CNT_W'(LOCK_STABLE_CYC);
      LCD_LOW:   ld = CNT_W'(LCD_RST_LOW_CYC);
      LCD_WAIT:  ld = CNT_W'(LCD_RST_WAIT_CYC);
      default:   ld = '0;
    endcase
    return ld;
  endfunction

  assign tmr_exp = (tmr_q == CNT_W'(1));

  // State and timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PLL_RST;
      tmr_q   <= CNT_W'(PLL_RST_CYC);
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Next state, timer reload/decrement and re-reset event.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    relock_evt = 1'b0;
    unique case (state_q)
      PLL_RST:   if (tmr_exp) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
        end else if (tmr_exp) begin
          state_d    = PLL_RST;
          relock_evt = 1'b1;
        end
      end
      // A lock drop wins over a simultaneous timer expiry.
      STABLE: begin
        if (!lock_s)      state_d = WAIT_LOCK;
        else if (tmr_exp) state_d = LCD_LOW;
      end
      LCD_LOW:   if (tmr_exp) state_d = LCD_WAIT;
      LCD_WAIT:  if (tmr_exp) state_d = RUN;
`ifdef LCD_PWR_SEQ_RELOCK_EN
      RUN: begin
        if (!lock_s) begin
          state_d    = PLL_RST;
          relock_evt = 1'b1;
        end
      end
`else
      RUN:       state_d = RUN;
`endif
      default:   state_d = PLL_RST;
    endcase

    if (state_d != state_q)  tmr_d = tmr_load(state_d);
    else if (state_q != RUN) tmr_d = tmr_q - CNT_W'(1);
  end

  // Registered outputs decoded from the next state, plus sticky status.
  always_comb begin
    out_d        = decode_outs(state_d);
    lock_lost_d  = lock_lost_q | ((state_q == RUN) & ~lock_s);
    relock_cnt_d = relock_cnt_q;
    if (relock_evt && (relock_cnt_q != '1)) relock_cnt_d = relock_cnt_q + RELOCK_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= OUT_RST;
      lock_lost_q  <= 1'b0;
      relock_cnt_q <= '0;
    end else begin
      out_q        <= out_d;
      lock_lost_q  <= lock_lost_d;
      relock_cnt_q <= relock_cnt_d;
    end
  end

  assign bus.pll_reset  = out_q.pll_reset;
  assign bus.lcd_rst_n  = out_q.lcd_rst_n;
  assign bus.sys_rst_n  = out_q.sys_rst_n;
  assign bus.bl_en      = out_q.bl_en;
  assign bus.ready      = out_q.ready;
  assign bus.lock_lost  = lock_lost_q;
  assign bus.relock_cnt = relock_cnt_q;

endmodule
